// File: rtl/fx_pt_pkg.sv
// Shared fixed-point definitions: number-encoding codes and the saturation limit helper
// used by both the adder and the requantiser.
package fx_pt_pkg;

   localparam int FX_UNSIGNED = 0;
   localparam int FX_TWOS     = 1;
   localparam int FX_SIGNMAG  = 2;

   // Largest magnitude representable in a width-bit word of the given encoding and sign.
   function automatic logic [63:0] fx_sat_limit(input int sgn, input int width, input logic neg);
      logic [63:0] half;
      half = 64'd1 << (width - 1);
      if (sgn == FX_UNSIGNED)
         return (64'd1 << width) - 64'd1;
      else if (sgn == FX_TWOS)
         return neg ? half : half - 64'd1;
      else
         return half - 64'd1;
   endfunction

endpackage

// File: rtl/fx_pt_requant_if.sv
// Handshake bundle for the requantiser: widened sum word in, narrowed operand word plus
// status flags out.
interface fx_pt_requant_if #(
   parameter int WIDTH = 15
);
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH:0]   sum;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   q;
   logic               ovf;
   logic               inexact;

   modport master (
      output in_valid, sum, out_ready,
      input  in_ready, out_valid, q, ovf, inexact
   );

   modport slave (
      input  in_valid, sum, out_ready,
      output in_ready, out_valid, q, ovf, inexact
   );
endinterface

// File: rtl/fx_pt_round_sat.sv
// Combinational round-to-nearest-even, saturation and re-encoding of a sign/magnitude
// pair into a WIDTH-bit word.
module fx_pt_round_sat
   import fx_pt_pkg::*;
#(
   parameter int SGN   = 2,
   parameter int WIDTH = 15,
   parameter int SHIFT = 14
) (
   input  logic [2*WIDTH:0]  mag,
   input  logic              sign,
   output logic [WIDTH-1:0]  q,
   output logic              ovf,
   output logic              inexact
);
   localparam int MW = 2*WIDTH + 1;
   localparam int KW = MW - SHIFT;
   localparam logic [MW-1:0] STICKY_MASK = (MW'(1) << (SHIFT - 1)) - MW'(1);

   logic [KW-1:0]     kept;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic [KW:0]       rnd;
   logic [63:0]       limit;
   logic [WIDTH-1:0]  res_mag;

   always_comb begin
      kept     = KW'(mag >> SHIFT);
      guard    = mag[SHIFT-1];
      sticky   = |(mag & STICKY_MASK);
      // Ties go to the even kept value; magnitude rounding is symmetric about zero.
      round_up = guard & (sticky | kept[0]);
      rnd      = {1'b0, kept} + {{KW{1'b0}}, round_up};
      limit    = fx_sat_limit(SGN, WIDTH, sign);

      if (64'(rnd) > limit) begin
         res_mag = WIDTH'(limit);
         ovf     = 1'b1;
         inexact = 1'b0;
      end else begin
         res_mag = WIDTH'(rnd);
         ovf     = 1'b0;
         inexact = guard | sticky;
      end

      q = '0;
      if (res_mag != '0) begin
         if (SGN == FX_TWOS)
            q = sign ? -res_mag : res_mag;
         else if (SGN == FX_UNSIGNED)
            q = res_mag;
         else
            q = {sign, res_mag[WIDTH-2:0]};
      end
   end

endmodule

// File: rtl/fx_pt_requant.sv
// Two-stage requantiser: decodes a widened sum into sign/magnitude, then rounds,
// saturates and re-encodes into a WIDTH-bit word behind a valid/ready handshake.
module fx_pt_requant
   import fx_pt_pkg::*;
#(
   parameter int SGN      = 2,
   parameter int WIDTH    = 15,
   parameter int IN_FRAC  = 15,
   parameter int OUT_FRAC = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   fx_pt_requant_if.slave  bus
);
   localparam int SHIFT = IN_FRAC - OUT_FRAC;
   localparam int MW    = 2*WIDTH + 1;

   logic              dec_sign;
   logic [MW-1:0]     dec_mag;
   logic              vld_p1;
   logic              sign_p1;
   logic [MW-1:0]     mag_p1;
   logic              ready_p1;
   logic              adv_p2;
   logic              out_valid_p2;
   logic [WIDTH-1:0]  q_p2;
   logic              ovf_p2;
   logic              inexact_p2;
   logic [WIDTH-1:0]  rs_q;
   logic              rs_ovf;
   logic              rs_inexact;

   always_comb begin
      dec_sign = 1'b0;
      dec_mag  = bus.sum;
      if (SGN == FX_TWOS) begin
         dec_sign = bus.sum[MW-1];
         dec_mag  = dec_sign ? -bus.sum : bus.sum;
      end else if (SGN != FX_UNSIGNED) begin
         dec_sign = bus.sum[MW-1];
         dec_mag  = {1'b0, bus.sum[MW-2:0]};
      end
      if (dec_mag == '0)
         dec_sign = 1'b0;
   end

   assign adv_p2   = !out_valid_p2 || bus.out_ready;
   assign ready_p1 = !vld_p1 || adv_p2;

   // Stage 1: decoded sign/magnitude
   always_ff @(posedge clk) begin
      if (bus.in_valid && ready_p1) begin
         sign_p1 <= dec_sign;
         mag_p1  <= dec_mag;
      end
   end

   fx_pt_round_sat #(
      .SGN   (SGN),
      .WIDTH (WIDTH),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .mag     (mag_p1),
      .sign    (sign_p1),
      .q       (rs_q),
      .ovf     (rs_ovf),
      .inexact (rs_inexact)
   );

   // Stage 2: rounded, saturated, encoded result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         out_valid_p2 <= 1'b0;
         q_p2         <= '0;
         ovf_p2       <= 1'b0;
         inexact_p2   <= 1'b0;
      end else begin
         if (ready_p1)
            vld_p1 <= bus.in_valid;
         if (adv_p2) begin
            out_valid_p2 <= vld_p1;
            if (vld_p1) begin
               q_p2       <= rs_q;
               ovf_p2     <= rs_ovf;
               inexact_p2 <= rs_inexact;
            end
         end
      end
   end

   assign bus.in_ready  = ready_p1;
   assign bus.out_valid = out_valid_p2;
   assign bus.q         = q_p2;
   assign bus.ovf       = ovf_p2;
   assign bus.inexact   = inexact_p2;

endmodule

// File: tb/tb_fx_pt_requant.sv
// Directed bench for fx_pt_requant: one instance per encoding, a table of hand-computed
// conversions, plus backpressure and mid-stream reset sequences.
module tb_fx_pt_requant;
   localparam int WIDTH = 15;
   localparam int NV    = 20;

   typedef struct packed {
      logic [1:0]  sel;
      logic [30:0] sum;
      logic [14:0] q;
      logic        ovf;
      logic        inx;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [30:0] sum = '0;
   int          sel = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        ov, ir, ovf_o, inx_o;
   logic [14:0] q_o;
   vec_t        vecs [NV];
   logic [30:0] bw [4];
   logic [14:0] bq [4];

   always #5 clk = ~clk;

   fx_pt_requant_if #(.WIDTH(WIDTH)) bus_u ();
   fx_pt_requant_if #(.WIDTH(WIDTH)) bus_t ();
   fx_pt_requant_if #(.WIDTH(WIDTH)) bus_s ();

   assign bus_u.in_valid = in_valid;
   assign bus_u.sum = sum;
   assign bus_u.out_ready = out_ready;
   assign bus_t.in_valid = in_valid;
   assign bus_t.sum = sum;
   assign bus_t.out_ready = out_ready;
   assign bus_s.in_valid = in_valid;
   assign bus_s.sum = sum;
   assign bus_s.out_ready = out_ready;

   fx_pt_requant #(.SGN(0), .WIDTH(WIDTH), .IN_FRAC(15), .OUT_FRAC(1)) dut_u (
      .clk(clk), .rst_n(rst_n), .bus(bus_u));
   fx_pt_requant #(.SGN(1), .WIDTH(WIDTH), .IN_FRAC(15), .OUT_FRAC(1)) dut_t (
      .clk(clk), .rst_n(rst_n), .bus(bus_t));
   fx_pt_requant #(.SGN(2), .WIDTH(WIDTH), .IN_FRAC(15), .OUT_FRAC(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s));

   always_comb begin
      case (sel)
         0: begin
            ov = bus_u.out_valid; ir = bus_u.in_ready; q_o = bus_u.q;
            ovf_o = bus_u.ovf; inx_o = bus_u.inexact;
         end
         1: begin
            ov = bus_t.out_valid; ir = bus_t.in_ready; q_o = bus_t.q;
            ovf_o = bus_t.ovf; inx_o = bus_t.inexact;
         end
         default: begin
            ov = bus_s.out_valid; ir = bus_s.in_ready; q_o = bus_s.q;
            ovf_o = bus_s.ovf; inx_o = bus_s.inexact;
         end
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      sel = int'(v.sel);
      @(negedge clk);
      in_valid = 1'b1; sum = v.sum; out_ready = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", idx), {31'd0, ir}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0; sum = '0;
      chk($sformatf("v%0d_lat1_valid", idx), {31'd0, ov}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_lat2_valid", idx), {31'd0, ov}, 32'd1);
      chk($sformatf("v%0d_q", idx), {17'd0, q_o}, {17'd0, v.q});
      chk($sformatf("v%0d_ovf", idx), {31'd0, ovf_o}, {31'd0, v.ovf});
      chk($sformatf("v%0d_inexact", idx), {31'd0, inx_o}, {31'd0, v.inx});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_n, got, cyc;
      logic take, emit;
      logic [14:0] held;

      //          sel   sum            q        ovf   inx
      vecs[0]  = '{2'd1, 31'h0000E000, 15'h0004, 1'b0, 1'b1};
      vecs[1]  = '{2'd1, 31'h0000A000, 15'h0002, 1'b0, 1'b1};
      vecs[2]  = '{2'd1, 31'h0000C000, 15'h0003, 1'b0, 1'b0};
      vecs[3]  = '{2'd1, 31'h7FFF2000, 15'h7FFC, 1'b0, 1'b1};
      vecs[4]  = '{2'd1, 31'h40000000, 15'h4000, 1'b1, 1'b0};
      vecs[5]  = '{2'd1, 31'h20000000, 15'h3FFF, 1'b1, 1'b0};
      vecs[6]  = '{2'd1, 31'h70000000, 15'h4000, 1'b0, 1'b0};
      vecs[7]  = '{2'd1, 31'h6FFFE000, 15'h4000, 1'b0, 1'b1};
      vecs[8]  = '{2'd1, 31'h0FFFE000, 15'h3FFF, 1'b1, 1'b0};
      vecs[9]  = '{2'd0, 31'h7FFFFFFF, 15'h7FFF, 1'b1, 1'b0};
      vecs[10] = '{2'd0, 31'h00016001, 15'h0006, 1'b0, 1'b1};
      vecs[11] = '{2'd0, 31'h1FFFC000, 15'h7FFF, 1'b0, 1'b0};
      vecs[12] = '{2'd0, 31'h1FFFE000, 15'h7FFF, 1'b1, 1'b0};
      vecs[13] = '{2'd2, 31'h40000000, 15'h0000, 1'b0, 1'b0};
      vecs[14] = '{2'd2, 31'h40014000, 15'h4005, 1'b0, 1'b0};
      vecs[15] = '{2'd2, 31'h40002000, 15'h0000, 1'b0, 1'b1};
      vecs[16] = '{2'd2, 31'h3FFFFFFF, 15'h3FFF, 1'b1, 1'b0};
      vecs[17] = '{2'd2, 31'h7FFFFFFF, 15'h7FFF, 1'b1, 1'b0};
      vecs[18] = '{2'd1, 31'h7FFF6000, 15'h7FFE, 1'b0, 1'b1};
      vecs[19] = '{2'd1, 31'h7FFFF000, 15'h0000, 1'b0, 1'b1};

      bw[0] = 31'h00004000; bq[0] = 15'h0001;
      bw[1] = 31'h00008000; bq[1] = 15'h0002;
      bw[2] = 31'h0000C000; bq[2] = 15'h0003;
      bw[3] = 31'h00010000; bq[3] = 15'h0004;

      // Reset state of every instance
      #1 rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk($sformatf("rst%0d_out_valid", s), {31'd0, ov}, 32'd0);
         chk($sformatf("rst%0d_in_ready", s), {31'd0, ir}, 32'd1);
         chk($sformatf("rst%0d_q", s), {17'd0, q_o}, 32'd0);
         chk($sformatf("rst%0d_flags", s), {30'd0, ovf_o, inx_o}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++)
         run_vec(vecs[i], i);

      // Backpressure: stall the output while offering four words
      sel = 1;
      acc_n = 0;
      @(negedge clk);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c != 0) @(negedge clk);
         in_valid = 1'b1;
         sum = bw[acc_n];
         #1 take = ir;
         @(posedge clk);
         if (take) acc_n++;
      end
      @(negedge clk);
      chk("bp_accepted", acc_n, 32'd2);
      chk("bp_in_ready_full", {31'd0, ir}, 32'd0);
      chk("bp_out_valid", {31'd0, ov}, 32'd1);
      chk("bp_head_q", {17'd0, q_o}, {17'd0, bq[0]});
      held = q_o;
      @(negedge clk);
      @(negedge clk);
      chk("bp_q_stable", {17'd0, q_o}, {17'd0, held});
      chk("bp_still_full", {31'd0, ir}, 32'd0);

      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 20) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid = (acc_n < 4);
         sum = (acc_n < 4) ? bw[acc_n] : '0;
         #1 take = in_valid && ir;
         emit = ov;
         if (emit) begin
            chk($sformatf("bp_out%0d_q", got), {17'd0, q_o}, {17'd0, bq[got]});
            got++;
         end
         cyc++;
         @(posedge clk);
         if (take) acc_n++;
      end
      in_valid = 1'b0;
      chk("bp_got", got, 32'd4);
      chk("bp_cycles", cyc, 32'd4);
      @(negedge clk);
      chk("bp_drained", {31'd0, ov}, 32'd0);

      // Mid-stream reset with both stages occupied
      out_ready = 1'b0;
      in_valid = 1'b1; sum = bw[0];
      @(negedge clk);
      sum = bw[1];
      @(negedge clk);
      in_valid = 1'b0; sum = '0;
      chk("mr_full_valid", {31'd0, ov}, 32'd1);
      chk("mr_full_ready", {31'd0, ir}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", {31'd0, ov}, 32'd0);
      chk("mr_q", {17'd0, q_o}, 32'd0);
      chk("mr_in_ready", {31'd0, ir}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; sum = bw[2]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sum = '0;
      chk("mr_lat1_valid", {31'd0, ov}, 32'd0);
      @(negedge clk);
      chk("mr_lat2_valid", {31'd0, ov}, 32'd1);
      chk("mr_q_new", {17'd0, q_o}, {17'd0, bq[2]});
      @(negedge clk);
      chk("mr_no_dup", {31'd0, ov}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
